instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Producer side of the fd_instruction interface: fetches 32-bit ARM words from instruction memory and presents them to
//  instruction_decoder. Keeps the fetch PC, runs a one-outstanding-request memory handshake and buffers prefetched words
//  in a small queue. Accepts PC redirects from the execute stage (branch / PC write) and flushes stale words.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  fetch PC after reset
//  QUEUE_DEPTH   2              prefetch queue entries; power of 2, >=2
//  TIMEOUT       255            cycles mem_req may stay unacknowledged before fetch_fault; 8-bit counter
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   asynchronous active-low reset
//  mem_req         out  1   instruction memory read request; held until mem_ack
//  mem_addr        out  32  word-aligned read address; stable while mem_req=1
//  mem_ack         in   1   read data valid this cycle; completes the request
//  mem_rdata       in   32  read data, sampled when mem_ack=1
//  fd_instruction  out  32  head-of-queue word to decoder; NOP_INSTR when queue empty
//  fd_valid        out  1   fd_instruction holds a real fetched word
//  fd_pc           out  32  address of presented word + 4 (PC as seen by executing instruction)
//  de_ready        in   1   decoder/execute consumes head this cycle (pop when fd_valid & de_ready)
//  redirect_en     in   1   execute wrote PC (branch, data-proc with Rd=R15)
//  redirect_addr   in   32  new fetch address; bits [1:0] ignored (forced 0)
//  fetch_fault     out  1   sticky: request timed out; cleared only by reset
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_VECTOR, queue empty, state IDLE, mem_req=0, mem_addr=RESET_VECTOR, fd_valid=0,
//   fd_instruction=NOP_INSTR (32'hE1A00000, MOV R0,R0), fd_pc=RESET_VECTOR+4, fetch_fault=0, timeout counter=0, discard=0.
//  States: IDLE -> REQ when (count + in-flight) < QUEUE_DEPTH and !fetch_fault and !redirect_en.
//   REQ: mem_req=1, mem_addr=fetch_pc. On mem_ack: push {mem_rdata, fetch_pc+4} unless discard; fetch_pc+=4;
//   discard<=0; -> REQ again if queue still has room after this push and any same-cycle pop, else IDLE.
//   FAULT: entered when counter reaches TIMEOUT in REQ with no ack; mem_req=0, fetch_fault=1; exit only by reset.
//  Handshake: mem_req never drops before mem_ack; mem_addr constant during a request; one request outstanding max.
//  Latency: ack in cycle N -> fd_valid=1 in N+1 (word registered in queue); no combinational mem_rdata->fd path.
//  Pop: fd_valid & de_ready removes head; next entry (if any) presented same next cycle. Push+pop same cycle: count unchanged.
//  Full: no new request issued; queue never overflows. Empty: fd_valid=0, fd_instruction=NOP_INSTR, fd_pc holds last value.
//  Redirect (priority over everything except reset): next cycle queue empty, fd_valid=0, fetch_pc=redirect_addr&~3.
//   If a request is outstanding and not acked in the redirect cycle: mem_req stays high with old address until ack,
//   discard=1, response dropped, then new request from redirect_addr. Ack in the redirect cycle is dropped.
//   Pop in redirect cycle ignored. Redirect while in FAULT: fetch_pc updated, state stays FAULT.
//  Timeout counter: clears on every ack and on entering REQ; saturates, never wraps.
//  fetch_pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
//  Queue pointers log2(QUEUE_DEPTH) bits wrapping naturally; count is log2(QUEUE_DEPTH)+1 bits.
// STRUCTURE
//  cpu_pkg: NOP_INSTR, fetch state encoding (IDLE/REQ/FAULT), instruction and address width constants, RESET_VECTOR default.
//  Sub-module fetch_queue: synchronous FIFO of {instr[31:0], pc[31:0]}, ports push/pop/flush/full/empty/count,
//   flush has priority over push and pop. Top holds FSM, fetch_pc, discard flag, timeout counter.
// TESTING
//  1 Reset, memory acks 1 cycle after req, de_ready=1 -> addrs 0,4,8... ; first fd_valid 2 cycles after first mem_req;
//    fd_pc=4 for word@0.
//  2 de_ready=0, instant ack -> exactly QUEUE_DEPTH requests (0,4), mem_req low; raise de_ready -> words
//    in order, request @8 resumes.
//  3 Redirect to 32'h0000_0103 while req@8 pending, ack 3 cycles later -> that word never reaches fd_valid;
//    next mem_addr=32'h100.
//  4 Redirect in same cycle as mem_ack and pop -> queue empty next cycle, fd_instruction=32'hE1A00000, next req at target.
//  5 Memory never acks -> fetch_fault=1 after TIMEOUT cycles, mem_req=0, fault persists through redirect; rst_n low mid-request
//    -> all outputs at reset values immediately, asynchronously.
//  6 Redirect to 32'hFFFF_FFF8, instant ack -> addrs FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: widths, NOP encoding, fetch FSM states and
// the prefetch queue entry layout.
package cpu_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR            = 32'hE1A0_0000; // MOV R0,R0
  localparam logic [ADDR_W-1:0]  RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {instr, pc+4} words; flush beats push and pop.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fq_entry_t                wdata_i,
  output fq_entry_t                rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  fq_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the fetch PC, a one-outstanding memory handshake with
// timeout, redirect/discard handling, and feeds the decoder from fetch_queue.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int                QUEUE_DEPTH  = 2,
  parameter int                TIMEOUT      = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] fd_instruction,
  output logic               fd_valid,
  output logic [ADDR_W-1:0]  fd_pc,
  input  logic               de_ready,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               fetch_fault
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q, mem_addr_q, hold_pc_q;
  logic              mem_req_q, fault_q, discard_q;
  logic [7:0]        tmo_q;

  logic              q_push, q_pop, q_full, q_empty, room;
  logic [CW-1:0]     q_count, q_count_nx;
  fq_entry_t         q_wdata, q_head;
  logic [ADDR_W-1:0] redir_pc, pc_adv;

  assign redir_pc = redirect_addr & ~32'h3;
  // A discarded response belongs to the pre-redirect stream, so the PC must not advance.
  assign pc_adv   = discard_q ? fetch_pc_q : fetch_pc_q + 32'd4;

  assign q_push  = (state_q == FS_REQ) && mem_ack && !discard_q && !redirect_en && !q_full;
  assign q_pop   = de_ready && !q_empty;
  assign q_wdata = '{instr: mem_rdata, pc: fetch_pc_q + 32'd4};

  assign q_count_nx = q_count + CW'(q_push) - CW'(q_pop);
  assign room       = int'(q_count_nx) < QUEUE_DEPTH;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .flush_i (redirect_en),
    .wdata_i (q_wdata),
    .rdata_o (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= RESET_VECTOR;
      mem_addr_q <= RESET_VECTOR;
      hold_pc_q  <= RESET_VECTOR + 32'd4;
      mem_req_q  <= 1'b0;
      fault_q    <= 1'b0;
      discard_q  <= 1'b0;
      tmo_q      <= 8'd0;
    end else begin
      if (!q_empty) hold_pc_q <= q_head.pc;
      case (state_q)
        FS_IDLE: begin
          if (redirect_en) begin
            fetch_pc_q <= redir_pc;
          end else if (int'(q_count) < QUEUE_DEPTH) begin
            state_q    <= FS_REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_pc_q;
            tmo_q      <= 8'd0;
          end
        end
        FS_REQ: begin
          if (mem_ack) begin
            tmo_q     <= 8'd0;
            discard_q <= 1'b0;
            if (redirect_en) begin
              fetch_pc_q <= redir_pc;
              state_q    <= FS_IDLE;
              mem_req_q  <= 1'b0;
            end else begin
              fetch_pc_q <= pc_adv;
              if (room) begin
                mem_addr_q <= pc_adv;
              end else begin
                state_q   <= FS_IDLE;
                mem_req_q <= 1'b0;
              end
            end
          end else begin
            if (tmo_q != 8'hFF) tmo_q <= tmo_q + 8'd1;
            if (redirect_en) begin
              // Request stays on the bus with its old address; its data is dropped later.
              fetch_pc_q <= redir_pc;
              discard_q  <= 1'b1;
            end else if (int'(tmo_q) >= TIMEOUT - 1) begin
              state_q   <= FS_FAULT;
              mem_req_q <= 1'b0;
              fault_q   <= 1'b1;
            end
          end
        end
        FS_FAULT: begin
          if (redirect_en) fetch_pc_q <= redir_pc;
        end
        default: state_q <= FS_IDLE;
      endcase
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;
  assign fetch_fault    = fault_q;
  assign fd_valid       = !q_empty;
  assign fd_instruction = q_empty ? NOP_INSTR : q_head.instr;
  assign fd_pc          = q_empty ? hold_pc_q : q_head.pc;
endmodule
